fft_stream_r2: RTL and testbench

- Parametrised successor to the fixed 8-point DIT FFT: iterative in-place radix-2 decimation-in-time FFT, N points, configurable sample and twiddle widths.
- Streams complex samples in and results out over valid/ready handshakes.
- Uses one butterfly per cycle over an internal sample store and a twiddle ROM built at elaboration.
- Sits between the sample front end and spectral post-processing.

---
 rtl/fft_stream_r2.sv | 196 +++++++++++++++++++
 tb/tb_fft_stream_r2.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_r2.sv
// Streaming N-point radix-2 DIT FFT: bit-reversed load, one in-place butterfly per cycle, natural-order dump.
// Optional macro FFT_INVERSE_EN adds an inv input that selects conjugate twiddles (IFFT) for a whole frame.
module fft_stream_r2 #(
  parameter int N     = 8,
  parameter int DW    = 12,
  parameter int TW_W  = 12,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef FFT_INVERSE_EN
  input  logic                 inv,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy
);
  localparam int LN   = $clog2(N);
  localparam int SW   = $clog2(LN);
  localparam int TMAX = 2**(TW_W-1) - 1;
  localparam int PW   = DW + TW_W + 1;
  localparam int EW   = DW + 2;
  localparam logic [SW-1:0]        TOP_STAGE = SW'(LN - 1);
  localparam logic signed [PW-1:0] RND       = PW'(2**(TW_W-2));
  localparam logic signed [EW-1:0] SAT_HI    = EW'(2**(DW-1) - 1);
  localparam logic signed [EW-1:0] SAT_LO    = EW'(-(2**(DW-1)));

  typedef enum logic [1:0] {S_LOAD, S_CALC, S_DUMP} state_t;

  state_t             state_q, state_d;
  logic [LN-1:0]      cnt_q, cnt_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [LN-2:0]      pair_q, pair_d;
  logic signed [DW-1:0] re_q [N];
  logic signed [DW-1:0] im_q [N];
  logic signed [DW-1:0] re_d [N];
  logic signed [DW-1:0] im_d [N];

  // Twiddle ROM W^k = exp(-i*2*pi*k/N); symmetric quantisation keeps +/-1.0 off the code space.
  logic signed [TW_W-1:0] tw_re [N/2];
  logic signed [TW_W-1:0] tw_im [N/2];
  for (genvar k = 0; k < N/2; k++) begin : g_tw
    localparam real ANG = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
    localparam int  CR  = int'($cos(ANG) * real'(TMAX));
    localparam int  CI  = int'(-$sin(ANG) * real'(TMAX));
    assign tw_re[k] = TW_W'(CR);
    assign tw_im[k] = TW_W'(CI);
  end

  function automatic logic [LN-1:0] bitrev(input logic [LN-1:0] v);
    logic [LN-1:0] r;
    for (int i = 0; i < LN; i++) r[i] = v[LN-1-i];
    return r;
  endfunction

  // One guard bit beyond DW+1 so saturation always sees the true sum.
  function automatic logic signed [DW-1:0] post(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] sh;
    sh = v >>> 1;
    if (SCALE != 0) return DW'(sh);
    if (v > SAT_HI) return DW'(SAT_HI);
    if (v < SAT_LO) return DW'(SAT_LO);
    return DW'(v);
  endfunction

  logic [LN-2:0]          mask, j, tw_idx;
  logic [LN-1:0]          addr_a, addr_b;
  logic signed [TW_W-1:0] wr, wi;
  logic signed [DW-1:0]   ar, ai, br, bi;
  logic signed [PW-1:0]   t_re_f, t_im_f;
  logic signed [DW:0]     t_re, t_im;
  logic signed [EW-1:0]   s_re, s_im, d_re, d_im;

`ifdef FFT_INVERSE_EN
  logic inv_q, inv_d;
`endif

  always_comb begin
    mask   = ~({(LN-1){1'b1}} << stage_q);
    j      = pair_q & mask;
    tw_idx = j << (TOP_STAGE - stage_q);
    addr_a = (({1'b0, pair_q} & ~{1'b0, mask}) << 1) | {1'b0, j};
    addr_b = addr_a | ({1'b0, mask} + 1'b1);
    ar = re_q[addr_a];
    ai = im_q[addr_a];
    br = re_q[addr_b];
    bi = im_q[addr_b];
    wr = tw_re[tw_idx];
`ifdef FFT_INVERSE_EN
    wi = inv_q ? -tw_im[tw_idx] : tw_im[tw_idx];
`else
    wi = tw_im[tw_idx];
`endif
    t_re_f = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi) + RND;
    t_im_f = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr) + RND;
    t_re   = (DW+1)'(t_re_f >>> (TW_W-1));
    t_im   = (DW+1)'(t_im_f >>> (TW_W-1));
    s_re   = EW'(ar) + EW'(t_re);
    s_im   = EW'(ai) + EW'(t_im);
    d_re   = EW'(ar) - EW'(t_re);
    d_im   = EW'(ai) - EW'(t_im);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    re_d    = re_q;
    im_d    = im_q;
`ifdef FFT_INVERSE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          re_d[bitrev(cnt_q)] = in_re;
          im_d[bitrev(cnt_q)] = in_im;
          cnt_d = cnt_q + 1'b1;
`ifdef FFT_INVERSE_EN
          if (cnt_q == '0) inv_d = inv;
`endif
          if (&cnt_q) begin
            state_d = S_CALC;
            stage_d = '0;
            pair_d  = '0;
          end
        end
      end
      S_CALC: begin
        re_d[addr_a] = post(s_re);
        im_d[addr_a] = post(s_im);
        re_d[addr_b] = post(d_re);
        im_d[addr_b] = post(d_im);
        pair_d = pair_q + 1'b1;
        if (&pair_q) begin
          stage_d = stage_q + 1'b1;
          if (stage_q == TOP_STAGE) begin
            state_d = S_DUMP;
            stage_d = '0;
          end
        end
      end
      S_DUMP: begin
        if (out_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      stage_q <= '0;
      pair_q  <= '0;
`ifdef FFT_INVERSE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
`ifdef FFT_INVERSE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  always_comb begin
    in_ready  = (state_q == S_LOAD);
    busy      = (state_q == S_CALC);
    out_valid = (state_q == S_DUMP);
    out_re    = out_valid ? re_q[cnt_q] : '0;
    out_im    = out_valid ? im_q[cnt_q] : '0;
    out_idx   = out_valid ? cnt_q : '0;
    out_last  = out_valid && (&cnt_q);
  end
endmodule

// File: tb/tb_fft_stream_r2.sv
// Bench for fft_stream_r2: two lockstep instances (scaled and saturating) against a plain-arithmetic FFT model.
`timescale 1ns/1ps
module tb_fft_stream_r2;
  localparam int  N   = 8;
  localparam int  LOG = 3;
  localparam int  DW  = 12;
  localparam int  TW  = 12;
  localparam int  M   = 2**(TW-1) - 1;
  localparam real PI  = 3.14159265358979323846;

  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [DW-1:0] in_re = '0, in_im = '0;
  logic in_ready, out_valid, out_last, busy;
  logic signed [DW-1:0] out_re, out_im;
  logic [LOG-1:0] out_idx;
  logic in_ready_s, out_valid_s, out_last_s, busy_s;
  logic signed [DW-1:0] out_re_s, out_im_s;
  logic [LOG-1:0] out_idx_s;
  bit inv_frame = 1'b0;
`ifdef FFT_INVERSE_EN
  logic inv = 1'b0;
`endif

  int n_chk = 0, n_fail = 0;
  int xr[N], xi[N], mr[N], mi[N], er1[N], ei1[N], er0[N], ei0[N];
  int cap_r[N], cap_i[N], cap_rs[N];

  always #5 clk = ~clk;

  fft_stream_r2 #(.N(N), .DW(DW), .TW_W(TW), .SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FFT_INVERSE_EN
    .inv(inv),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .busy(busy));

  fft_stream_r2 #(.N(N), .DW(DW), .TW_W(TW), .SCALE(0)) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef FFT_INVERSE_EN
    .inv(inv),
`endif
    .in_valid(in_valid), .in_ready(in_ready_s), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_re(out_re_s), .out_im(out_im_s),
    .out_idx(out_idx_s), .out_last(out_last_s), .busy(busy_s));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < LOG; b++) if (((k >> b) & 1) != 0) r |= 1 << (LOG - 1 - b);
    return r;
  endfunction

  function automatic longint post(input longint v, input int sc);
    if (sc != 0) return v >>> 1;
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Textbook iterative DIT FFT with the block's rounding, scaling and saturation rules.
  task automatic model(input int sc);
    longint vr[N], vi[N];
    for (int k = 0; k < N; k++) begin
      vr[brev(k)] = xr[k];
      vi[brev(k)] = xi[k];
    end
    for (int s = 0; s < LOG; s++) begin
      for (int p = 0; p < N/2; p++) begin
        int h, g, j, a, b;
        real ang;
        longint wr, wi, tr, ti, ar, ai;
        h = 1 << s; g = p / h; j = p % h; a = g * 2 * h + j; b = a + h;
        ang = 2.0 * PI * real'(j * (N / (2 * h))) / real'(N);
        wr = int'($cos(ang) * real'(M));
        wi = int'(-$sin(ang) * real'(M));
        if (inv_frame) wi = -wi;
        tr = (vr[b] * wr - vi[b] * wi + 2**(TW-2)) >>> (TW - 1);
        ti = (vr[b] * wi + vi[b] * wr + 2**(TW-2)) >>> (TW - 1);
        ar = vr[a]; ai = vi[a];
        vr[a] = post(ar + tr, sc); vi[a] = post(ai + ti, sc);
        vr[b] = post(ar - tr, sc); vi[b] = post(ai - ti, sc);
      end
    end
    for (int k = 0; k < N; k++) begin
      mr[k] = int'(vr[k]);
      mi[k] = int'(vi[k]);
    end
  endtask

  task automatic prepare();
    model(1); er1 = mr; ei1 = mi;
    model(0); er0 = mr; ei0 = mi;
  endtask

  task automatic send_frame();
    int w;
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_re = DW'(xr[k]);
      in_im = DW'(xi[k]);
`ifdef FFT_INVERSE_EN
      inv = (k == 0) ? inv_frame : !inv_frame;
`endif
      w = 0;
      while (!in_ready && w < 1000) begin @(posedge clk); #1; w++; end
      if (w >= 1000) chk("in_ready_wait", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat = 1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_calc"}, in_ready, 0);
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, N/2 * LOG + 1);
  endtask

  task automatic collect(input string tag, input bit toggle);
    int got = 0, cyc = 0;
    bit held = 1'b0;
    logic signed [DW-1:0] pr = '0, pim = '0, prs = '0;
    logic [LOG-1:0] pidx = '0;
    while (got < N && cyc < 500) begin
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (out_valid) begin
        chk({tag, "_in_ready_dump"}, in_ready, 0);
        if (held) begin
          chk({tag, "_hold_re"}, out_re, pr);
          chk({tag, "_hold_im"}, out_im, pim);
          chk({tag, "_hold_idx"}, out_idx, pidx);
          chk({tag, "_hold_re_s"}, out_re_s, prs);
        end
        if (out_ready) begin
          chk({tag, "_idx"}, out_idx, got);
          chk({tag, "_last"}, out_last, (got == N - 1));
          chk({tag, "_re"}, out_re, er1[got]);
          chk({tag, "_im"}, out_im, ei1[got]);
          chk({tag, "_re_sat"}, out_re_s, er0[got]);
          chk({tag, "_im_sat"}, out_im_s, ei0[got]);
          cap_r[got] = out_re; cap_i[got] = out_im; cap_rs[got] = out_re_s;
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          pr = out_re; pim = out_im; pidx = out_idx; prs = out_re_s;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_count"}, got, N);
    chk({tag, "_out_valid_after"}, out_valid, 0);
    chk({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input bit toggle);
    prepare();
    send_frame();
    wait_out(tag);
    collect(tag, toggle);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #5;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) begin xr[k] = (k == 0) ? 100 : 0; xi[k] = 0; end
    run("impulse", 1'b0);
    for (int k = 0; k < N; k++) begin
      chk("impulse_const_re", cap_r[k], 12);
      chk("impulse_const_im", cap_i[k], 0);
    end

    for (int k = 0; k < N; k++) begin xr[k] = 80; xi[k] = 0; end
    run("dc", 1'b0);
    for (int k = 0; k < N; k++) chk("dc_const_re", cap_r[k], (k == 0) ? 80 : 0);

    for (int k = 0; k < N; k++) begin xr[k] = (k % 2 == 0) ? 64 : -64; xi[k] = 0; end
    run("alt_stall", 1'b1);
    for (int k = 0; k < N; k++) begin
      chk("alt_const_re", cap_r[k], (k == 4) ? 64 : 0);
      chk("alt_const_im", cap_i[k], 0);
    end

    for (int k = 0; k < N; k++) begin xr[k] = 2047; xi[k] = 0; end
    run("saturate", 1'b0);
    chk("saturate_bin0", cap_rs[0], 2047);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        xr[k] = int'($urandom_range(1000)) - 500;
        xi[k] = int'($urandom_range(1000)) - 500;
      end
      run("random", r[0]);
    end

    for (int k = 0; k < N; k++) begin xr[k] = (k == 0) ? 100 : 0; xi[k] = 0; end
    prepare();
    send_frame();
    repeat (4) begin @(posedge clk); #1; end
    chk("midcalc_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midcalc_rst_out_valid", out_valid, 0);
    chk("midcalc_rst_busy", busy, 0);
    chk("midcalc_rst_in_ready", in_ready, 1);
    chk("midcalc_rst_out_re", out_re, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midcalc_release_in_ready", in_ready, 1);
    chk("midcalc_release_busy", busy, 0);
    run("after_reset", 1'b0);
    for (int k = 0; k < N; k++) chk("after_reset_const_re", cap_r[k], 12);

`ifdef FFT_INVERSE_EN
    for (int k = 0; k < N; k++) begin xr[k] = (k == 4) ? 64 : 0; xi[k] = 0; end
    inv_frame = 1'b1;
    run("inverse", 1'b0);
    for (int k = 0; k < N; k++) chk("inverse_const_re", cap_r[k], (k % 2 == 0) ? 8 : -8);
    inv_frame = 1'b0;
    for (int k = 0; k < N; k++) begin xr[k] = (k == 0) ? 100 : 0; xi[k] = 0; end
    run("forward_again", 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
